// File: rtl/fetch_pc_gen.sv
// Multi-lane next-PC generator for the pre-IF stage: issues one aligned fetch group per
// accepted icache request, applies flush/correction redirects and owes delay-slot groups.
module fetch_pc_gen #(
  parameter int unsigned FETCH_WIDTH   = 2,
  parameter logic [31:0] RESET_PC      = 32'hbfc00000,
  parameter logic [31:0] EX_VECTOR     = 32'hbfc00380,
  parameter logic [31:0] REFILL_VECTOR = 32'hbfc00200,
  localparam int unsigned SW = (FETCH_WIDTH > 1) ? $clog2(FETCH_WIDTH) : 1
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   fs_allowin,
  input  logic                   ex_flush,
  input  logic                   ex_refill,
  input  logic                   eret_flush,
  input  logic [31:0]            epc,
  input  logic                   refetch_flush,
  input  logic [31:0]            refetch_pc,
  input  logic                   correct_valid,
  input  logic [31:0]            correct_target,
  input  logic                   predict_valid,
  input  logic                   predict_taken,
  input  logic [SW-1:0]          predict_slot,
  input  logic [31:0]            predict_target,
  output logic                   icache_req,
  output logic [31:0]            icache_vaddr,
  input  logic                   icache_addr_ok,
  output logic                   fs_valid_o,
  output logic [31:0]            fs_pc,
  output logic [FETCH_WIDTH-1:0] fs_lane_mask,
  output logic                   fs_ex_adel,
  output logic                   fs_bd_first,
  output logic [1:0]             dbg_state
);

  // Handshake: a request is accepted in a cycle where icache_req & icache_addr_ok; the
  // group is handed to IF (fs_valid_o) in that same cycle. Without accept, pc and state hold.

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    DS_PEND = 2'd2,
    EX_HOLD = 2'd3
  } state_t;

  localparam logic [SW-1:0] LAST        = SW'(FETCH_WIDTH - 1);
  localparam logic [31:0]   GROUP_BYTES = 32'(4 * FETCH_WIDTH);

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   ds_target_q, ds_target_d;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [SW-1:0] off;
  logic [SW-1:0] pred_last;
  logic [SW-1:0] hi;
  logic [31:0]   group_base;
  logic [31:0]   seq_pc;
  logic          active;
  logic          pred_hit;

  assign dbg_state  = state_q;
  assign off        = SW'((pc_q >> 2) & 32'(FETCH_WIDTH - 1));
  assign group_base = pc_q & ~(GROUP_BYTES - 32'd1);
  assign seq_pc     = group_base + GROUP_BYTES;
  assign active     = ((state_q == RUN) || (state_q == DS_PEND)) && fs_allowin;
  assign redirect   = ex_flush | eret_flush | refetch_flush | correct_valid;
  assign pred_last  = (predict_slot == LAST) ? LAST : predict_slot + SW'(1);
  assign pred_hit   = (state_q == RUN) && predict_valid && predict_taken &&
                      (predict_slot >= off);

  // Fixed priority: exception > eret > refetch > branch correction.
  always_comb begin
    redirect_pc = correct_target;
    if (ex_flush)
      redirect_pc = ex_refill ? REFILL_VECTOR : EX_VECTOR;
    else if (eret_flush)
      redirect_pc = epc;
    else if (refetch_flush)
      redirect_pc = refetch_pc;
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ds_target_d  = ds_target_q;
    icache_req   = 1'b0;
    icache_vaddr = (state_q == BOOT) ? 32'h0 : pc_q;
    fs_valid_o   = 1'b0;
    fs_pc        = 32'h0;
    fs_lane_mask = '0;
    fs_ex_adel   = 1'b0;
    fs_bd_first  = 1'b0;
    hi           = LAST;

    if (state_q == BOOT) begin
      state_d = RUN;
    end else if (redirect) begin
      state_d = RUN;
      pc_d    = redirect_pc;
    end else if (active && (pc_q[1:0] != 2'b00)) begin
      // Misaligned fetch: report AdEL on the faulting lane and wait for the flush.
      fs_valid_o = 1'b1;
      fs_pc      = pc_q;
      fs_ex_adel = 1'b1;
      hi         = off;
      state_d    = EX_HOLD;
    end else if (active) begin
      icache_req = 1'b1;
      if (icache_addr_ok) begin
        fs_valid_o = 1'b1;
        fs_pc      = pc_q;
        if (state_q == DS_PEND) begin
          hi          = off;
          fs_bd_first = 1'b1;
          pc_d        = ds_target_q;
          state_d     = RUN;
        end else if (pred_hit) begin
          hi = pred_last;
          // A branch in the last lane leaves its delay slot for the next group.
          if (predict_slot == LAST) begin
            ds_target_d = predict_target;
            pc_d        = seq_pc;
            state_d     = DS_PEND;
          end else begin
            pc_d = predict_target;
          end
        end else begin
          pc_d = seq_pc;
        end
      end
    end

    if (fs_valid_o) begin
      for (int i = 0; i < FETCH_WIDTH; i++)
        fs_lane_mask[i] = (SW'(i) >= off) && (SW'(i) <= hi);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      ds_target_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ds_target_q <= ds_target_d;
    end
  end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen (W=2): directed scenarios then random stimulus, scored against a
// lane-address model of the fetch rules.
module tb_fetch_pc_gen;
  localparam int          W          = 2;
  localparam int          SW         = 1;
  localparam int          EW         = 32 + W + 2;
  localparam logic [31:0] RESET_PC   = 32'hbfc00000;
  localparam logic [31:0] EX_VEC     = 32'hbfc00380;
  localparam logic [31:0] REFILL_VEC = 32'hbfc00200;

  logic          clk = 1'b0;
  logic          resetn;
  logic          fs_allowin, ex_flush, ex_refill, eret_flush, refetch_flush, correct_valid;
  logic [31:0]   epc, refetch_pc, correct_target, predict_target;
  logic          predict_valid, predict_taken;
  logic [SW-1:0] predict_slot;
  logic          icache_req, icache_addr_ok;
  logic [31:0]   icache_vaddr, fs_pc;
  logic          fs_valid_o, fs_ex_adel, fs_bd_first;
  logic [W-1:0]  fs_lane_mask;
  logic [1:0]    dbg_state;

  fetch_pc_gen #(.FETCH_WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .fs_allowin(fs_allowin),
    .ex_flush(ex_flush), .ex_refill(ex_refill), .eret_flush(eret_flush), .epc(epc),
    .refetch_flush(refetch_flush), .refetch_pc(refetch_pc),
    .correct_valid(correct_valid), .correct_target(correct_target),
    .predict_valid(predict_valid), .predict_taken(predict_taken),
    .predict_slot(predict_slot), .predict_target(predict_target),
    .icache_req(icache_req), .icache_vaddr(icache_vaddr), .icache_addr_ok(icache_addr_ok),
    .fs_valid_o(fs_valid_o), .fs_pc(fs_pc), .fs_lane_mask(fs_lane_mask),
    .fs_ex_adel(fs_ex_adel), .fs_bd_first(fs_bd_first), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  logic [32:0]   req_q[$];
  int            errors = 0;
  int            checks = 0;
  bit            done = 1'b0;

  // Reference model: current fetch address, owed delay slot, halted after AdEL.
  logic [31:0] m_pc, m_ds_tgt;
  bit          m_boot, m_owed, m_halted;

  task automatic model_cycle();
    logic [31:0] nxt, base, va;
    logic [W-1:0] mask;
    logic bd, req;
    int first, last, slot;
    req = 1'b0;
    va  = 32'h0;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (ex_flush || eret_flush || refetch_flush || correct_valid) begin
      if (ex_flush)           m_pc = ex_refill ? REFILL_VEC : EX_VEC;
      else if (eret_flush)    m_pc = epc;
      else if (refetch_flush) m_pc = refetch_pc;
      else                    m_pc = correct_target;
      m_owed   = 1'b0;
      m_halted = 1'b0;
    end else if (!m_halted && fs_allowin) begin
      first = int'((m_pc >> 2) % W);
      if (m_pc % 4 != 0) begin
        mask = '0;
        mask[first] = 1'b1;
        exp_q.push_back({m_pc, mask, 1'b1, 1'b0});
        m_halted = 1'b1;
      end else begin
        req = 1'b1;
        va  = m_pc;
        if (icache_addr_ok) begin
          base = m_pc - (m_pc % (4 * W));
          last = W - 1;
          bd   = 1'b0;
          slot = int'(predict_slot);
          if (m_owed) begin
            last   = first;
            bd     = 1'b1;
            nxt    = m_ds_tgt;
            m_owed = 1'b0;
          end else if (predict_valid && predict_taken && slot >= first) begin
            last = (slot + 1 < W - 1) ? slot + 1 : W - 1;
            if (slot == W - 1) begin
              m_ds_tgt = predict_target;
              m_owed   = 1'b1;
              nxt      = base + 4 * W;
            end else begin
              nxt = predict_target;
            end
          end else begin
            nxt = base + 4 * W;
          end
          for (int i = 0; i < W; i++) mask[i] = (i >= first) && (i <= last);
          exp_q.push_back({m_pc, mask, 1'b0, bd});
          m_pc = nxt;
        end
      end
    end
    req_q.push_back({req, va});
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    fs_allowin = 1'b1; icache_addr_ok = 1'b1;
    ex_flush = 1'b0; ex_refill = 1'b0; eret_flush = 1'b0; refetch_flush = 1'b0;
    correct_valid = 1'b0; predict_valid = 1'b0; predict_taken = 1'b0; predict_slot = '0;
    epc = 32'h0; refetch_pc = 32'h0; correct_target = 32'h0; predict_target = 32'h0;
  endtask

  task automatic tick();
    model_cycle();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic jump(input logic [31:0] a);
    correct_valid = 1'b1; correct_target = a;
    tick();
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = 32'h80000000 | ($urandom & 32'h0000fffc);
    if ($urandom_range(0, 19) == 0) a = a | 32'($urandom_range(1, 3));
    if ($urandom_range(0, 29) == 0) a = 32'hfffffff0 | ($urandom & 32'hc);
    return a;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EW-1:0] e, g;
    logic [32:0]   r, rg;
    if (done) begin
      checks++;
      if (exp_q.size() != 0 || req_q.size() != 0) begin
        errors++;
        $display("FAIL leftover: got %0d/%0d pending, expected 0/0", exp_q.size(), req_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end else if (!resetn) begin
      checks++;
      if ({icache_req, fs_valid_o, fs_ex_adel, fs_bd_first, fs_lane_mask, fs_pc} != '0) begin
        errors++;
        $display("FAIL reset_outputs: got req=%b v=%b adel=%b bd=%b mask=%b pc=%h, expected all 0",
                 icache_req, fs_valid_o, fs_ex_adel, fs_bd_first, fs_lane_mask, fs_pc);
      end
    end else begin
      if (req_q.size() > 0) begin
        r  = req_q.pop_front();
        rg = {icache_req, icache_req ? icache_vaddr : 32'h0};
        checks++;
        if (rg !== r) begin
          errors++;
          $display("FAIL icache_req: got req=%b vaddr=%h, expected req=%b vaddr=%h",
                   rg[32], rg[31:0], r[32], r[31:0]);
        end
      end
      g = {fs_pc, fs_lane_mask, fs_ex_adel, fs_bd_first};
      if (fs_valid_o) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_group: got pc=%h mask=%b adel=%b bd=%b, expected no group",
                   fs_pc, fs_lane_mask, fs_ex_adel, fs_bd_first);
        end else begin
          e = exp_q.pop_front();
          if (g !== e) begin
            errors++;
            $display("FAIL group: got pc=%h mask=%b adel=%b bd=%b, expected pc=%h mask=%b adel=%b bd=%b",
                     g[EW-1 -: 32], g[W+1:2], g[1], g[0], e[EW-1 -: 32], e[W+1:2], e[1], e[0]);
          end
        end
      end else if (exp_q.size() > 0) begin
        checks++;
        errors++;
        e = exp_q.pop_front();
        $display("FAIL missing_group: got fs_valid_o=0, expected pc=%h mask=%b", e[EW-1 -: 32], e[W+1:2]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    resetn = 1'b0;
    idle();
    m_boot = 1'b1; m_pc = RESET_PC; m_ds_tgt = 32'h0; m_owed = 1'b0; m_halted = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    tick();                                   // BOOT cycle
    tick(); tick();                           // bfc00000 then bfc00008
    jump(32'hbfc00004); tick(); tick();       // partial group, mask 10
    jump(32'h80000000);
    predict_valid = 1'b1; predict_taken = 1'b1; predict_slot = 1'b0;
    predict_target = 32'h80001000; tick(); tick();
    jump(32'h80000000);
    predict_valid = 1'b1; predict_taken = 1'b1; predict_slot = 1'b1;
    predict_target = 32'h80002000; tick(); tick(); tick();
    jump(32'h80000004);                       // slot 0 below offset: ignored
    predict_valid = 1'b1; predict_taken = 1'b1; predict_slot = 1'b0;
    predict_target = 32'h80003000; tick(); tick();
    jump(32'h80000000);                       // owe delay slot, then flush it away
    predict_valid = 1'b1; predict_taken = 1'b1; predict_slot = 1'b1;
    predict_target = 32'h80004000; tick();
    repeat (3) begin icache_addr_ok = 1'b0; tick(); end
    ex_flush = 1'b1; eret_flush = 1'b1; epc = 32'h80005000; tick(); tick(); tick();
    jump(32'h80000102); tick(); tick(); tick(); // AdEL then hold
    ex_flush = 1'b1; tick(); tick();
    eret_flush = 1'b1; refetch_flush = 1'b1; epc = 32'h80006000; refetch_pc = 32'h80007000; tick();
    refetch_flush = 1'b1; correct_valid = 1'b1; refetch_pc = 32'h80008000; tick();
    ex_flush = 1'b1; ex_refill = 1'b1; tick(); tick();
    ex_refill = 1'b1; tick();                 // ignored without ex_flush
    jump(32'hfffffff8); tick(); tick();       // wrap to 0
    fs_allowin = 1'b0; tick();
    for (int n = 0; n < 3000; n++) begin
      fs_allowin     = ($urandom_range(0, 7) != 0);
      icache_addr_ok = ($urandom_range(0, 3) != 0);
      predict_valid  = 1'($urandom_range(0, 1));
      predict_taken  = 1'($urandom_range(0, 1));
      predict_slot   = 1'($urandom_range(0, 1));
      predict_target = rand_addr();
      ex_refill      = 1'($urandom_range(0, 1));
      epc            = rand_addr();
      refetch_pc     = rand_addr();
      correct_target = rand_addr();
      if ($urandom_range(0, 9) == 0)
        {ex_flush, eret_flush, refetch_flush, correct_valid} = 4'($urandom_range(1, 15));
      tick();
    end
    fs_allowin = 1'b0;
    done = 1'b1;
  end

endmodule
